// File: rtl/alu_mul_seq.sv
// Sequential 16x16 unsigned multiplier (low 16 bits) built on a single shared 16-bit ALU.
// Shift-and-add: one ADD and one DBL cycle per multiplier bit, then a one-cycle DONE.

module alu16 (
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic        zx_i,
  input  logic        nx_i,
  input  logic        zy_i,
  input  logic        ny_i,
  input  logic        f_i,
  input  logic        no_i,
  output logic [15:0] out_o,
  output logic        zr_o,
  output logic        ng_o
);
  logic [15:0] x_z, x_n, y_z, y_n, f_out;

  always_comb begin
    x_z   = zx_i ? 16'h0000 : x_i;
    x_n   = nx_i ? ~x_z : x_z;
    y_z   = zy_i ? 16'h0000 : y_i;
    y_n   = ny_i ? ~y_z : y_z;
    f_out = f_i ? (x_n + y_n) : (x_n & y_n);
    out_o = no_i ? ~f_out : f_out;
    zr_o  = (out_o == 16'h0000);
    ng_o  = out_o[15];
  end
endmodule

module alu_mul_seq #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] product_o,
  output logic        ovf_o,
  output logic        zr_o,
  output logic        ng_o
);
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAdd  = 2'd1;
  localparam logic [1:0] StDbl  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  // Thermometer count: bit k set once k+1 doublings are done, so no incrementer is needed.
  logic [15:0] count_q, count_d;
  logic        lost_q, lost_d;
  logic        ovf_int_q, ovf_int_d;
  logic [15:0] product_q, product_d;
  logic        ovf_q, ovf_d, zr_q, zr_d, ng_q, ng_d;

  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_zy, alu_zr, alu_ng;
  logic        last_bit;

  alu16 u_alu (
    .x_i   (alu_x),
    .y_i   (alu_y),
    .zx_i  (1'b0),
    .nx_i  (1'b0),
    .zy_i  (alu_zy),
    .ny_i  (1'b0),
    .f_i   (1'b1),
    .no_i  (1'b0),
    .out_o (alu_out),
    .zr_o  (alu_zr),
    .ng_o  (alu_ng)
  );

  // ADD: acc+mcand, DBL: mcand+mcand, DONE: pass acc through for the flags.
  always_comb begin
    alu_x  = acc_q;
    alu_y  = mcand_q;
    alu_zy = 1'b0;
    case (state_q)
      StDbl:   alu_x  = mcand_q;
      StDone:  alu_zy = 1'b1;
      default: ;
    endcase
  end

  assign last_bit = count_q[14] || (EARLY_EXIT && (mplier_q[15:1] == 15'h0000));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    lost_d    = lost_q;
    ovf_int_d = ovf_int_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    zr_d      = zr_q;
    ng_d      = ng_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          acc_d     = 16'h0000;
          mcand_d   = a_i;
          mplier_d  = b_i;
          count_d   = 16'h0000;
          lost_d    = 1'b0;
          ovf_int_d = 1'b0;
          state_d   = StAdd;
        end
      end
      StAdd: begin
        if (mplier_q[0]) begin
          acc_d = alu_out;
          // Carry out, or a multiplicand bit already shifted past bit 15, means overflow.
          if ((alu_out < acc_q) || lost_q) ovf_int_d = 1'b1;
        end
        state_d = StDbl;
      end
      StDbl: begin
        mcand_d  = alu_out;
        lost_d   = lost_q | mcand_q[15];
        mplier_d = {1'b0, mplier_q[15:1]};
        count_d  = {count_q[14:0], 1'b1};
        state_d  = last_bit ? StDone : StAdd;
      end
      default: begin
        product_d = acc_q;
        ovf_d     = ovf_int_q;
        zr_d      = alu_zr;
        ng_d      = alu_ng;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      acc_q     <= 16'h0000;
      mcand_q   <= 16'h0000;
      mplier_q  <= 16'h0000;
      count_q   <= 16'h0000;
      lost_q    <= 1'b0;
      ovf_int_q <= 1'b0;
      product_q <= 16'h0000;
      ovf_q     <= 1'b0;
      zr_q      <= 1'b1;
      ng_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      lost_q    <= lost_d;
      ovf_int_q <= ovf_int_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
      zr_q      <= zr_d;
      ng_q      <= ng_d;
    end
  end

  // During DONE the result is shown straight from acc; the registered copy holds it afterwards.
  always_comb begin
    busy_o    = (state_q != StIdle);
    done_o    = (state_q == StDone);
    product_o = done_o ? acc_q     : product_q;
    ovf_o     = done_o ? ovf_int_q : ovf_q;
    zr_o      = done_o ? alu_zr    : zr_q;
    ng_o      = done_o ? alu_ng    : ng_q;
  end
endmodule
